// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, functs, FSM states, exception codes and ALU ops for the multicycle MIPS core
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_BUS     = 2'b10;
  localparam logic [1:0] EXC_OVF     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;

endpackage

// File: rtl/mips_mc_alu.sv
// rtl/mips_mc_alu.sv - combinational ALU with zero and signed-overflow flags
module mips_mc_alu
  import mips_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  // result and signed overflow; overflow only meaningful for add/sub
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[31] == b[31]) && (result[31] != a[31]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[31] != b[31]) && (result[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_LUI: result = {b[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multicycle MIPS core on one req/ack memory port (optional overflow trap: MIPS_MC_OVERFLOW_TRAP_EN)
module mips_mc_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic [1:0]  exc
);

`ifdef MIPS_MC_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam bit          TO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(ACK_TIMEOUT - 1) : 32'd0;

  state_t      state;
  logic        run_en;
  logic [31:0] pc, ir, mdr, a_q, b_q, imm_q, alu_q, to_cnt;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  alu_op_t     alu_op;
  logic        legal, use_imm, zext, ovf_chk;
  logic        is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
  logic [4:0]  wb_reg;

  // instruction decode from IR; IR is stable from DECODE through WB
  always_comb begin
    legal = 1'b0; alu_op = ALU_ADD; use_imm = 1'b1; zext = 1'b0; ovf_chk = 1'b0;
    is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
    is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; wb_reg = rt;
    case (opcode)
      OP_RTYPE: begin
        use_imm = 1'b0;
        wb_reg  = rd;
        case (funct)
          FN_SLL:  begin legal = 1'b1; alu_op = ALU_SLL; end
          FN_SRL:  begin legal = 1'b1; alu_op = ALU_SRL; end
          FN_JR:   begin legal = 1'b1; is_jr = 1'b1; end
          FN_ADD:  begin legal = 1'b1; alu_op = ALU_ADD; ovf_chk = TRAP_EN; end
          FN_ADDU: begin legal = 1'b1; alu_op = ALU_ADD; end
          FN_SUB:  begin legal = 1'b1; alu_op = ALU_SUB; ovf_chk = TRAP_EN; end
          FN_SUBU: begin legal = 1'b1; alu_op = ALU_SUB; end
          FN_AND:  begin legal = 1'b1; alu_op = ALU_AND; end
          FN_OR:   begin legal = 1'b1; alu_op = ALU_OR; end
          FN_SLT:  begin legal = 1'b1; alu_op = ALU_SLT; end
          default: legal = 1'b0;
        endcase
      end
      OP_J:     begin legal = 1'b1; is_j = 1'b1; end
      OP_JAL:   begin legal = 1'b1; is_jal = 1'b1; end
      OP_BEQ:   begin legal = 1'b1; is_beq = 1'b1; use_imm = 1'b0; alu_op = ALU_SUB; end
      OP_BNE:   begin legal = 1'b1; is_bne = 1'b1; use_imm = 1'b0; alu_op = ALU_SUB; end
      OP_ADDI:  begin legal = 1'b1; ovf_chk = TRAP_EN; end
      OP_ADDIU: legal = 1'b1;
      OP_SLTI:  begin legal = 1'b1; alu_op = ALU_SLT; end
      OP_ORI:   begin legal = 1'b1; alu_op = ALU_OR; zext = 1'b1; end
      OP_LUI:   begin legal = 1'b1; alu_op = ALU_LUI; end
      OP_LW:    begin legal = 1'b1; is_lw = 1'b1; end
      OP_SW:    begin legal = 1'b1; is_sw = 1'b1; end
      default:  legal = 1'b0;
    endcase
  end

  logic [31:0] imm_ext, alu_b, alu_result, pc4, exec_npc;
  logic        alu_zero, alu_ovf, is_ctrl, to_expire;

  assign imm_ext   = zext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
  assign alu_b     = use_imm ? imm_q : b_q;
  assign pc4       = pc + 32'd4;
  assign is_ctrl   = is_jr | is_j | is_jal | is_beq | is_bne;
  assign to_expire = TO_EN && !mem_ack && (to_cnt == TO_LAST);
  assign pc_out    = pc;

  mips_mc_alu u_alu (
    .op       (alu_op),
    .a        (a_q),
    .b        (alu_b),
    .shamt    (shamt),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  // next PC for control-transfer instructions resolved in EXEC
  always_comb begin
    exec_npc = pc4;
    if (is_jr)
      exec_npc = a_q & ~32'h3;
    else if (is_j || is_jal)
      exec_npc = {pc4[31:28], ir[25:0], 2'b00};
    else if ((is_beq && alu_zero) || (is_bne && !alu_zero))
      exec_npc = pc4 + (imm_q << 2);
  end

  // main FSM; memory port outputs are registered and follow the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE; run_en <= 1'b0; pc <= RESET_PC;
      ir <= '0; mdr <= '0; a_q <= '0; b_q <= '0; imm_q <= '0; alu_q <= '0; to_cnt <= '0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      halted <= 1'b0; exc <= EXC_NONE;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      // IDLE holds one extra cycle after reset release before the first fetch
      run_en <= 1'b1;
      case (state)
        S_IDLE: if (run_en) begin
          state <= S_FETCH; mem_req <= 1'b1; mem_addr <= pc; to_cnt <= '0;
        end
        S_FETCH, S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0; mem_we <= 1'b0;
            if (state == S_FETCH) begin
              ir <= mem_rdata; state <= S_DECODE;
            end else if (is_lw) begin
              mdr <= mem_rdata; state <= S_WB;
            end else begin
              pc <= pc4; state <= S_FETCH; mem_req <= 1'b1; mem_addr <= pc4; to_cnt <= '0;
            end
          end else if (to_expire) begin
            state <= S_HALT; mem_req <= 1'b0; mem_we <= 1'b0; halted <= 1'b1; exc <= EXC_BUS;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            state <= S_HALT; halted <= 1'b1; exc <= EXC_ILLEGAL;
          end else begin
            a_q <= rf[rs]; b_q <= rf[rt]; imm_q <= imm_ext; state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ctrl) begin
            if (is_jal) rf[31] <= pc4;
            pc <= exec_npc; state <= S_FETCH; mem_req <= 1'b1; mem_addr <= exec_npc; to_cnt <= '0;
          end else if (is_lw || is_sw) begin
            state <= S_MEM; mem_req <= 1'b1; mem_we <= is_sw;
            mem_addr <= alu_result & ~32'h3; mem_wdata <= b_q; to_cnt <= '0;
          end else if (ovf_chk && alu_ovf) begin
            state <= S_HALT; halted <= 1'b1; exc <= EXC_OVF;
          end else begin
            alu_q <= alu_result; state <= S_WB;
          end
        end
        S_WB: begin
          if (wb_reg != 5'd0) rf[wb_reg] <= is_lw ? mdr : alu_q;
          pc <= pc4; state <= S_FETCH; mem_req <= 1'b1; mem_addr <= pc4; to_cnt <= '0;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - directed self-checking bench for mips_mc_core
module tb_mips_mc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] pc_out;
  logic        halted;
  logic [1:0]  exc;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wait_n = 0;
  int wcnt = 0;
  int wr_cnt = 0;
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  mips_mc_core #(.RESET_PC(32'h0), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_out(pc_out), .halted(halted), .exc(exc)
  );

  always @(posedge clk) cyc++;

  // memory responder: ack after wait_n wait cycles per access
  always @(negedge clk) begin
    if (mem_ack) wcnt = 0;
    if (mem_req && rst) begin
      if (wcnt >= wait_n) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        if (mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          wr_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFC00_0000;
    wr_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input int max, output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (mem_req && !mem_we && mem_addr == addr) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic wait_halt(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    wait_n = 5;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({mem_req, mem_we, halted, exc} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=00000", {mem_req, mem_we, halted, exc}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h/%h want=0/0", mem_addr, mem_wdata); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_out); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL req_edge1 got=%b want=0", mem_req); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL req_edge2 got=%b/%h want=1/0", mem_req, mem_addr); end
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_abort got=%b want=0", mem_req); end
  endtask

  task automatic test_program();
    int t0, t1; bit ok;
    clear_mem();
    mem[0] = 32'h3401_0005; mem[1] = 32'h2422_FFFF; mem[2] = 32'hAC02_0000; mem[3] = 32'h8C03_0000;
    wait_n = 0;
    do_reset();
    wait_fetch(32'h0, 10, t0, ok);
    wait_fetch(32'h10, 40, t1, ok);
    total++; if (!ok || (t1 - t0) != 17) begin bad++; $display("FAIL prog_cycles got=%0d ok=%0d want=17", t1 - t0, ok); end
    wait_halt(20, ok);
    total++; if (dut.rf[3] !== 32'd4) begin bad++; $display("FAIL prog_r3 got=%h want=4", dut.rf[3]); end
    total++; if (mem[0] !== 32'd4) begin bad++; $display("FAIL prog_mem0 got=%h want=4", mem[0]); end
  endtask

  task automatic test_branch_wait();
    int t0, t1; bit ok; bit stable;
    clear_mem();
    mem[0] = 32'h1000_0002;
    wait_n = 3;
    do_reset();
    wait_fetch(32'h0, 10, t0, ok);
    stable = ok;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (!(mem_req && !mem_we && mem_addr == 32'h0)) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("FAIL wait_stable got=%b/%h want=1/0", mem_req, mem_addr); end
    wait_fetch(32'hC, 20, t1, ok);
    total++; if (!ok || (t1 - t0) != 6) begin bad++; $display("FAIL beq_wait got=%0d ok=%0d want=6", t1 - t0, ok); end
  endtask

  task automatic test_jal_jr();
    int t0, t1; bit ok;
    clear_mem();
    mem[0] = 32'h0800_0040; mem[64] = 32'h0C00_0080; mem[128] = 32'h03E0_0008;
    wait_n = 0;
    do_reset();
    wait_fetch(32'h100, 20, t0, ok);
    total++; if (!ok) begin bad++; $display("FAIL j_fetch got=timeout want=0x100"); end
    wait_fetch(32'h200, 20, t1, ok);
    total++; if (!ok || (t1 - t0) != 3) begin bad++; $display("FAIL jal_fetch got=%0d ok=%0d want=3", t1 - t0, ok); end
    total++; if (dut.rf[31] !== 32'h104) begin bad++; $display("FAIL jal_r31 got=%h want=104", dut.rf[31]); end
    wait_fetch(32'h104, 20, t0, ok);
    total++; if (!ok || (t0 - t1) != 3 || pc_out !== 32'h104) begin bad++; $display("FAIL jr_fetch got=%0d pc=%h want=3 pc=104", t0 - t1, pc_out); end
  endtask

  task automatic test_alu();
    bit ok;
    int          ridx [9] = '{3, 4, 5, 6, 7, 8, 9, 10, 11};
    logic [31:0] rexp [9] = '{32'h0001_00F0, 32'hF0, 32'hFFFF_00F0, 32'h1, 32'hF00,
                              32'h00FF_FF00, 32'h1, 32'h0, 32'h55};
    clear_mem();
    mem[0]  = 32'h3401_00F0; mem[1]  = 32'h3C02_FFFF; mem[2]  = 32'h0022_1823; mem[3]  = 32'h0023_2024;
    mem[4]  = 32'h0022_2825; mem[5]  = 32'h0041_302A; mem[6]  = 32'h0001_3900; mem[7]  = 32'h0002_4202;
    mem[8]  = 32'h2849_FFFB; mem[9]  = 32'h1422_0001; mem[10] = 32'h340A_0001; mem[11] = 32'h1022_0001;
    mem[12] = 32'h3400_0009; mem[13] = 32'h340B_0055;
    wait_n = 1;
    do_reset();
    wait_halt(200, ok);
    total++; if (!ok || exc !== 2'b01 || pc_out !== 32'h38) begin bad++; $display("FAIL alu_end got=%0d/%b/%h want=1/01/38", ok, exc, pc_out); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (dut.rf[ridx[i]] !== rexp[i]) begin bad++; $display("FAIL alu_r%0d got=%h want=%h", ridx[i], dut.rf[ridx[i]], rexp[i]); end
    end
  endtask

  task automatic test_illegal();
    bit ok;
    clear_mem();
    mem[0] = 32'h3401_0007; mem[1] = 32'hFC22_0000;
    wait_n = 0;
    do_reset();
    wait_halt(30, ok);
    total++; if (!ok || exc !== 2'b01) begin bad++; $display("FAIL ill_exc got=%0d/%b want=1/01", ok, exc); end
    total++; if (dut.rf[1] !== 32'h7 || dut.rf[2] !== 32'h0) begin bad++; $display("FAIL ill_regs got=%h/%h want=7/0", dut.rf[1], dut.rf[2]); end
    total++; if (wr_cnt != 0 || pc_out !== 32'h4) begin bad++; $display("FAIL ill_side got=%0d/%h want=0/4", wr_cnt, pc_out); end
    repeat (3) @(posedge clk); #1;
    total++; if (mem_req !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL ill_hold got=%b/%b want=0/1", mem_req, halted); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_mem();
    mem[0] = 32'h3C01_7FFF; mem[1] = 32'h3421_FFFF; mem[2] = 32'h3402_0001; mem[3] = 32'h0022_1820;
    wait_n = 0;
    do_reset();
    wait_halt(60, ok);
    total++; if (dut.rf[1] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf_r1 got=%h want=7fffffff", dut.rf[1]); end
`ifdef MIPS_MC_OVERFLOW_TRAP_EN
    total++; if (!ok || exc !== 2'b11 || pc_out !== 32'hC) begin bad++; $display("FAIL ovf_trap got=%0d/%b/%h want=1/11/c", ok, exc, pc_out); end
    total++; if (dut.rf[3] !== 32'h0) begin bad++; $display("FAIL ovf_rd got=%h want=0", dut.rf[3]); end
`else
    total++; if (!ok || exc !== 2'b01 || pc_out !== 32'h10) begin bad++; $display("FAIL ovf_nontrap got=%0d/%b/%h want=1/01/10", ok, exc, pc_out); end
    total++; if (dut.rf[3] !== 32'h8000_0000) begin bad++; $display("FAIL ovf_rd got=%h want=80000000", dut.rf[3]); end
`endif
  endtask

  task automatic test_timeout();
    int t0; int n; bit ok;
    clear_mem();
    wait_n = 100000;
    do_reset();
    wait_fetch(32'h0, 10, t0, ok);
    n = ok ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_req) n++; else break;
    end
    total++; if (n != 8) begin bad++; $display("FAIL to_len got=%0d want=8", n); end
    total++; if (halted !== 1'b1 || exc !== 2'b10) begin bad++; $display("FAIL to_exc got=%b/%b want=1/10", halted, exc); end
    repeat (3) @(posedge clk); #1;
    total++; if (mem_req !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL to_hold got=%b/%b want=0/1", mem_req, halted); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_branch_wait();
    test_jal_jr();
    test_alu();
    test_illegal();
    test_overflow();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
# mips_mc_core

Multicycle MIPS core: the successor to the single-cycle top, sharing one word-wide memory port for instruction fetch and data access through a req/ack handshake with variable wait states. A state machine sequences FETCH/DECODE/EXEC/MEM/WB per instruction. An optional ack timeout and exception reporting halt the core on faults. It sits between the SoC memory/interconnect and nothing upstream: it is the CPU.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ACK_TIMEOUT, 0, max cycles mem_req may wait for mem_ack before bus-error halt; 0 disables the timeout.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  access request; addr/we/wdata stable while high.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  32  byte address, bits [1:0] always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ack is high.
- mem_ack  in  1  completes the access on the edge where mem_req && mem_ack.
- pc_out  out  32  PC of the instruction in flight.
- halted  out  1  core stopped; only reset clears it.
- exc  out  2  00 none, 01 illegal opcode/funct, 10 bus timeout, 11 arithmetic overflow.

## Operation
- ISA: addu, subu, and, or, slt, sll, srl, jr, addiu, slti, ori, lui, lw, sw, beq, bne, j, jal; add/sub/addi per Configuration. No delay slots. Word accesses only.
- Register file: 32x32, r0 reads 0, and writes to r0 are discarded. Writes occur only in WB or in EXEC for jal.
- States and transitions:
  - IDLE to FETCH.
  - FETCH to DECODE on ack; IR <= mem_rdata.
  - DECODE: latch A = rs and B = rt, form sign- or zero-extended immediate. Go to EXEC, or to HALT with exc=01 if the opcode/funct is unsupported.
  - EXEC: R/I ALU ops go to WB. lw/sw compute address and go to MEM. beq/bne/j/jr/jal update PC and go to FETCH.
  - MEM: lw goes to WB on ack, latching MDR. sw goes to FETCH on ack.
  - WB: write rd (R-type), rt (I-type), or MDR (lw); PC += 4; go to FETCH.
  - HALT: absorbing state.
- PC rules:
  - Branch taken: PC = PC+4 + (sext(imm)<<2). Not taken: PC+4.
  - j/jal: {PC+4[31:28], target, 2'b00}. jal writes PC+4 to r31.
  - jr: PC = rs.
  - All arithmetic is modulo 2^32.
  - Shifts use shamt and B.
  - slt/slti compare signed.
  - ori zero-extends the immediate; lui places imm in [31:16].
- mem_req is high exactly in FETCH and MEM. mem_we is high only in MEM for sw.
- Timeout: the counter clears on entering FETCH/MEM. If ACK_TIMEOUT>0 and the count reaches ACK_TIMEOUT without ack, go to HALT with exc=10 and drop mem_req.

## Timing
- Reset values: state IDLE, PC=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, exc=00, all registers 0.
- First mem_req is asserted on the second rising edge after rst deasserts.
- Zero-wait cycle counts: ALU ops 4, lw 5, sw 4, branch/jump 3. Each wait cycle adds 1.
- The handshake completes in the same cycle as ack. mem_req drops in the cycle after completion. ack while mem_req=0 is ignored.
- halted and exc are registered and set on the edge entering HALT. In HALT, mem_req=0.
- Reset asserted mid-access aborts immediately. No state survives.

## Configuration
- MIPS_MC_OVERFLOW_TRAP_EN defined:
  - add/sub/addi are legal.
  - Signed overflow suppresses writeback and goes to HALT with exc=11; PC stays at the faulting instruction.
- MIPS_MC_OVERFLOW_TRAP_EN undefined: add/sub/addi behave as addu/subu/addiu and exc=11 is never produced.

## Structure
- Package mips_pkg: opcode and funct localparams, state enum, exc code constants, ALU-op enum.
- One sub-module, mips_mc_alu: combinational; ALU-op, A, B, shamt in; result, zero and overflow out.
- Register file, IR, MDR, A/B latches and FSM live in mips_mc_core.

## Test plan
- Zero-wait program `ori r1,r0,5; addiu r2,r1,-1; sw r2,0(r0); lw r3,0(r0)` → r3=4, mem[0]=4, total 17 cycles from the first FETCH.
- mem_ack delayed 3 cycles on every access for `beq r0,r0,+2` at 0 → mem_addr/mem_req stable through the wait, next fetch at 0x0C after 6 cycles.
- `jal` at 0x100 with target field 0x80 → PC=0x200, r31=0x104. Then `jr r31` → fetch at 0x104.
- ACK_TIMEOUT=8, mem_ack held 0 → halted=1 and exc=10 on the 8th cycle of mem_req; mem_req=0 afterwards.
- Opcode 6'h3F → halted=1, exc=01, no register or memory write.
- With MIPS_MC_OVERFLOW_TRAP_EN, `add` of 0x7FFFFFFF and 1 → exc=11, rd unchanged. Without it, rd=0x80000000.
